// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 byte receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK_CODE      = 8'hF0;
  localparam int         PS2_DEFAULT_TIMEOUT = 50000;

  // PS/2 frames use odd parity over the data byte plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-stage synchronizer plus falling-edge detector for the PS/2 lines.
// Every flop resets to 1 so an idle bus never produces a spurious edge.
module ps2_sync_edge #(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_signal,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stages [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  // Synchronizer chain and previous-value register.
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stages[i] <= '1;
      end
      prev <= '1;
    end else begin
      stages[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stages[i] <= stages[i-1];
      end
      prev <= stages[SYNC_STAGES-1];
    end
  end

  assign sync = stages[SYNC_STAGES-1];
  assign fall = prev & ~stages[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_byte_receiver.sv
// PS/2 keyboard byte receiver: start, 8 data bits LSB first, odd parity, stop.
// Optional key-release filtering is enabled with macro PS2_BREAK_FILTER_EN.
module ps2_byte_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PS2_DEFAULT_TIMEOUT,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset_signal,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       parity_error,
  output logic       frame_error
);

  localparam int              TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    line_sync;
  logic [1:0]    line_fall;
  logic          clk_fall;
  logic          data_bit;
  logic          unused_lines;

  ps2_state_t    state, state_next;
  logic [2:0]    bit_count, bit_count_next;
  logic [TW-1:0] timeout_count, timeout_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_bit, parity_next;
  logic [7:0]    rx_byte_next;
  logic          valid_next, perr_next, ferr_next;
`ifdef PS2_BREAK_FILTER_EN
  logic          break_pending, pending_next;
`endif

  ps2_sync_edge #(
    .WIDTH       (2),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clock        (clock),
    .reset_signal (reset_signal),
    .async_in     ({ps2_clk, ps2_data}),
    .sync         (line_sync),
    .fall         (line_fall)
  );

  assign clk_fall     = line_fall[1];
  assign data_bit     = line_sync[0];
  assign unused_lines = line_sync[1] ^ line_fall[0];

  // Next-state, datapath and pulse decode.
  always_comb begin
    state_next     = state;
    bit_count_next = bit_count;
    timeout_next   = timeout_count;
    shift_next     = shift_reg;
    parity_next    = parity_bit;
    rx_byte_next   = rx_byte;
    valid_next     = 1'b0;
    perr_next      = 1'b0;
    ferr_next      = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    pending_next   = break_pending;
`endif

    if (state == IDLE) begin
      timeout_next = '0;
      if (clk_fall && !data_bit) begin
        state_next     = DATA;
        bit_count_next = 3'd0;
      end else begin
        ferr_next = clk_fall;
      end
    end else if (!clk_fall) begin
      // Stalled frame: give up and discard whatever was shifted in.
      if (timeout_count == TIMEOUT_LAST) begin
        ferr_next      = 1'b1;
        state_next     = IDLE;
        bit_count_next = 3'd0;
        timeout_next   = '0;
        shift_next     = 8'h00;
      end else begin
        timeout_next = timeout_count + TW'(1);
      end
    end else begin
      timeout_next = '0;
      case (state)
        DATA: begin
          shift_next     = {data_bit, shift_reg[7:1]};
          bit_count_next = bit_count + 3'd1;
          if (bit_count == 3'd7) begin
            state_next = PARITY;
          end else begin
            state_next = DATA;
          end
        end
        PARITY: begin
          parity_next = data_bit;
          state_next  = STOP;
        end
        STOP: begin
          state_next     = IDLE;
          bit_count_next = 3'd0;
          if (!data_bit) begin
            ferr_next = 1'b1;
          end else if (!odd_parity_ok(shift_reg, parity_bit)) begin
            perr_next = 1'b1;
          end else begin
`ifdef PS2_BREAK_FILTER_EN
            if (break_pending) begin
              pending_next = 1'b0;
            end else if (shift_reg == PS2_BREAK_CODE) begin
              pending_next = 1'b1;
            end else begin
              rx_byte_next = shift_reg;
              valid_next   = 1'b1;
            end
`else
            rx_byte_next = shift_reg;
            valid_next   = 1'b1;
`endif
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

`ifdef PS2_BREAK_FILTER_EN
    pending_next = pending_next & ~(perr_next | ferr_next);
`endif
  end

  // State, datapath and registered output pulses.
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      state         <= IDLE;
      bit_count     <= 3'd0;
      timeout_count <= '0;
      shift_reg     <= 8'h00;
      parity_bit    <= 1'b0;
      rx_byte       <= 8'h00;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      frame_error   <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      break_pending <= 1'b0;
`endif
    end else begin
      state         <= state_next;
      bit_count     <= bit_count_next;
      timeout_count <= timeout_next;
      shift_reg     <= shift_next;
      parity_bit    <= parity_next;
      rx_byte       <= rx_byte_next;
      rx_valid      <= valid_next;
      parity_error  <= perr_next;
      frame_error   <= ferr_next;
`ifdef PS2_BREAK_FILTER_EN
      break_pending <= pending_next;
`endif
    end
  end

endmodule
